// File: rtl/alarm_button_conditioner.sv
// alarm_button_conditioner: sync, debounce, edge-detect and auto-repeat the six alarm buttons
//   clk_1k/rst            : 1 kHz clock, synchronous active-high reset
//   raw_set_btn[2:0]      : async set buttons {sec, min, hour}
//   raw_confirm/cancel/stop : async command buttons
//   alarm_btn_t[2:0]      : one-cycle set pulses (press + auto-repeat)
//   btn_confirm/cancel/stop : one-cycle command pulses, stop > cancel > confirm
//   btn_level[5:0]        : debounced levels {stop, cancel, confirm, sec, min, hour}
module alarm_button_conditioner #(
  parameter int DEBOUNCE_MS     = 20,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic       clk_1k,
  input  logic       rst,
  input  logic [2:0] raw_set_btn,
  input  logic       raw_confirm,
  input  logic       raw_cancel,
  input  logic       raw_stop,
  output logic [2:0] alarm_btn_t,
  output logic       btn_confirm,
  output logic       btn_cancel,
  output logic       btn_stop,
  output logic [5:0] btn_level
);
  localparam int DW   = $clog2(DEBOUNCE_MS);
  localparam int HMAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
  localparam int HW   = $clog2(HMAX + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_MS - 1);
  localparam logic [HW-1:0] DELAY_N = HW'(REPEAT_DELAY_MS);
  localparam logic [HW-1:0] RATE_N  = HW'(REPEAT_RATE_MS);
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
  logic [5:0] raw_in, stable_nx, rise;
  logic [2:0] cmd_d, cmd_q;
  assign raw_in = {raw_stop, raw_cancel, raw_confirm, raw_set_btn} ^ {6{ACTIVE_LOW}};
  genvar i;
  for (i = 0; i < 6; i++) begin : g_db
    logic sync1_q, sync2_q, stable_d, stable_q;
    logic [DW-1:0] db_cnt_d, db_cnt_q;
    always_comb begin
      stable_d = (sync2_q != stable_q && db_cnt_q == DB_LAST) ? sync2_q : stable_q;
      db_cnt_d = (sync2_q == stable_q || db_cnt_q == DB_LAST) ? '0 : db_cnt_q + 1'b1;
    end
    always_ff @(posedge clk_1k) begin
      if (rst) begin
        sync1_q  <= 1'b0;
        sync2_q  <= 1'b0;
        stable_q <= 1'b0;
        db_cnt_q <= '0;
      end else begin
        sync1_q  <= raw_in[i];
        sync2_q  <= sync1_q;
        stable_q <= stable_d;
        db_cnt_q <= db_cnt_d;
      end
    end
    assign stable_nx[i] = stable_d;
    assign btn_level[i] = stable_q;
  end
  // Rising edge of the next debounced level, so pulses register on the same edge the level flips
  assign rise = stable_nx & ~btn_level;
  always_comb cmd_d = rise[5] ? 3'b100 : rise[4] ? 3'b010 : {2'b00, rise[3]};
  always_ff @(posedge clk_1k) cmd_q <= rst ? 3'b000 : cmd_d;
  assign {btn_stop, btn_cancel, btn_confirm} = cmd_q;
  for (i = 0; i < 3; i++) begin : g_rep
    state_t state_d, state_q;
    logic [HW-1:0] hold_d, hold_q, hold_inc;
    logic pulse_d, pulse_q;
    assign hold_inc = hold_q + 1'b1;
    // Release is taken from the next level so no repeat pulse can coincide with the falling edge
    always_comb begin
      state_d = state_q;
      hold_d  = hold_inc;
      pulse_d = 1'b0;
      if (!stable_nx[i]) begin
        state_d = IDLE;
        hold_d  = '0;
      end else if (rise[i]) begin
        state_d = DELAY;
        hold_d  = '0;
        pulse_d = 1'b1;
      end else if (state_q == DELAY && hold_inc == DELAY_N) begin
        state_d = REPEAT;
        hold_d  = '0;
        pulse_d = 1'b1;
      end else if (state_q == REPEAT && hold_inc == RATE_N) begin
        hold_d  = '0;
        pulse_d = 1'b1;
      end else if (state_q == IDLE) begin
        hold_d  = '0;
      end
    end
    always_ff @(posedge clk_1k) begin
      if (rst) begin
        state_q <= IDLE;
        hold_q  <= '0;
        pulse_q <= 1'b0;
      end else begin
        state_q <= state_d;
        hold_q  <= hold_d;
        pulse_q <= pulse_d;
      end
    end
    assign alarm_btn_t[i] = pulse_q;
  end
endmodule
